// File: rtl/algorithm_sequencer.sv
// Front-panel controller for the scaling coprocessor: debounces the NEXT and
// START pushbuttons, cycles the algorithm selection (NN, PR, DC, BA), launches
// one coprocessor run per start press and tracks completion or timeout.
module algorithm_sequencer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int TIMEOUT_CYCLES  = 16777216
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       KEY_NEXT_N,
  input  logic       KEY_START_N,
  input  logic       COP_DONE,
  output logic [1:0] ALGORITHM,
  output logic       COP_START,
  output logic       BUSY,
  output logic       DONE_LED,
  output logic       ERROR
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_MAX  = '1;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    FINISH,
    FAULT
  } state_t;

  logic [1:0] key_n;
  logic [1:0] press;
  logic       next_press;
  logic       start_press;

  assign key_n       = {KEY_START_N, KEY_NEXT_N};
  assign next_press  = press[0];
  assign start_press = press[1];

  for (genvar k = 0; k < 2; k++) begin : g_key
    logic          meta_p0;
    logic          sync_p1;
    logic          db_lvl_p2;
    logic          db_dly_p3;
    logic          press_p4;
    logic [CW-1:0] db_cnt;

    // Synchronize, debounce and turn a debounced falling edge into a one-cycle press.
    always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
        meta_p0   <= 1'b1;
        sync_p1   <= 1'b1;
        db_lvl_p2 <= 1'b1;
        db_dly_p3 <= 1'b1;
        press_p4  <= 1'b0;
        db_cnt    <= '0;
      end else begin
        // p0 -> p1: two-flop synchronizer for the asynchronous button
        meta_p0 <= key_n[k];
        sync_p1 <= meta_p0;
        // p1 -> p2: level accepted only after it has differed long enough
        if (sync_p1 != db_lvl_p2) begin
          if (db_cnt == DB_LAST) begin
            db_lvl_p2 <= sync_p1;
            db_cnt    <= '0;
          end else begin
            db_cnt <= db_cnt + CW'(1);
          end
        end else begin
          db_cnt <= '0;
        end
        // p2 -> p4: release-to-press edge only; release itself is silent
        db_dly_p3 <= db_lvl_p2;
        press_p4  <= db_dly_p3 & ~db_lvl_p2;
      end
    end

    assign press[k] = press_p4;
  end

  state_t        state;
  state_t        state_d;
  logic [1:0]    algorithm_d;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_d;

  // Next-state, selection and run timer; presses outside IDLE/FINISH/FAULT are dropped.
  always_comb begin
    state_d     = state;
    algorithm_d = ALGORITHM;
    timer_d     = timer;
    case (state)
      IDLE: begin
        if (start_press) begin
          state_d = LAUNCH;
        end else if (next_press) begin
          algorithm_d = ALGORITHM + 2'd1;
        end
      end
      LAUNCH: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (timer != TIMER_MAX) begin
          timer_d = timer + TW'(1);
        end
        if (COP_DONE) begin
          state_d = FINISH;
        end else if (timer == TIMER_LAST) begin
          state_d = FAULT;
        end
      end
      FINISH: begin
        if (start_press) begin
          state_d = LAUNCH;
        end else if (next_press) begin
          algorithm_d = ALGORITHM + 2'd1;
          state_d     = IDLE;
        end
      end
      FAULT: begin
        if (start_press) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; every output is decoded from the state being entered.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      timer     <= '0;
      ALGORITHM <= 2'd0;
      COP_START <= 1'b0;
      BUSY      <= 1'b0;
      DONE_LED  <= 1'b0;
      ERROR     <= 1'b0;
    end else begin
      state     <= state_d;
      timer     <= timer_d;
      ALGORITHM <= algorithm_d;
      COP_START <= (state_d == LAUNCH);
      BUSY      <= (state_d == LAUNCH) || (state_d == WAIT);
      DONE_LED  <= (state_d == FINISH);
      ERROR     <= (state_d == FAULT);
    end
  end

endmodule

// File: tb/tb_algorithm_sequencer.sv
// Directed bench for algorithm_sequencer with a scoreboard of expected
// algorithm changes and expected launches.
module tb_algorithm_sequencer;

  localparam int DB = 4;
  localparam int TO = 32;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       KEY_NEXT_N;
  logic       KEY_START_N;
  logic       COP_DONE;
  logic [1:0] ALGORITHM;
  logic       COP_START;
  logic       BUSY;
  logic       DONE_LED;
  logic       ERROR;

  int n_checks = 0;
  int n_pass   = 0;

  logic [1:0] exp_alg;
  logic [1:0] prev_alg;
  bit         mon_en = 1'b0;
  logic [1:0] alg_q[$];
  logic [1:0] launch_q[$];

  algorithm_sequencer #(
    .DEBOUNCE_CYCLES(DB),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .KEY_NEXT_N (KEY_NEXT_N),
    .KEY_START_N(KEY_START_N),
    .COP_DONE   (COP_DONE),
    .ALGORITHM  (ALGORITHM),
    .COP_START  (COP_START),
    .BUSY       (BUSY),
    .DONE_LED   (DONE_LED),
    .ERROR      (ERROR)
  );

  always #5 CLK = ~CLK;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
  endtask

  task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic press_next();
    KEY_NEXT_N = 1'b0;
    tick(20);
    KEY_NEXT_N = 1'b1;
    tick(20);
  endtask

  // Scoreboard: every ALGORITHM change and every COP_START cycle must be expected.
  always @(negedge CLK) begin
    if (mon_en) begin
      if (ALGORITHM !== prev_alg) begin
        if (alg_q.size() == 0) chk2("alg_spurious_change", ALGORITHM, prev_alg);
        else chk2("alg_sb", ALGORITHM, alg_q.pop_front());
        prev_alg = ALGORITHM;
      end
      if (COP_START === 1'b1) begin
        if (launch_q.size() == 0) chk1("cop_start_spurious", COP_START, 1'b0);
        else chk2("launch_alg_sb", ALGORITHM, launch_q.pop_front());
      end
    end
  end

  initial begin
    RESET       = 1'b1;
    KEY_NEXT_N  = 1'b1;
    KEY_START_N = 1'b1;
    COP_DONE    = 1'b0;
    exp_alg     = 2'd0;
    tick(3);
    chk2("rst_alg", ALGORITHM, 2'd0);
    chk1("rst_cop_start", COP_START, 1'b0);
    chk1("rst_busy", BUSY, 1'b0);
    chk1("rst_done", DONE_LED, 1'b0);
    chk1("rst_error", ERROR, 1'b0);
    RESET    = 1'b0;
    prev_alg = 2'd0;
    mon_en   = 1'b1;
    tick(2);

    // 1: four clean next presses step 1,2,3,0
    for (int i = 0; i < 4; i++) begin
      exp_alg = exp_alg + 2'd1;
      alg_q.push_back(exp_alg);
      press_next();
      chk2("t1_alg", ALGORITHM, exp_alg);
      chk1("t1_busy", BUSY, 1'b0);
      chk1("t1_cop_start", COP_START, 1'b0);
      chk1("t1_done", DONE_LED, 1'b0);
      chk1("t1_error", ERROR, 1'b0);
    end

    // 2: short glitch ignored, long hold gives one increment after 7 cycles
    KEY_NEXT_N = 1'b0;
    tick(3);
    KEY_NEXT_N = 1'b1;
    tick(20);
    chk2("t2_glitch", ALGORITHM, exp_alg);
    exp_alg = exp_alg + 2'd1;
    alg_q.push_back(exp_alg);
    KEY_NEXT_N = 1'b0;
    tick(7);
    chk2("t2_before", ALGORITHM, exp_alg - 2'd1);
    tick(1);
    chk2("t2_after", ALGORITHM, exp_alg);
    tick(42);
    KEY_NEXT_N = 1'b1;
    tick(20);
    chk2("t2_once", ALGORITHM, exp_alg);

    // 3: run on algorithm 2 with COP_DONE 10 cycles after launch
    exp_alg = 2'd2;
    alg_q.push_back(exp_alg);
    press_next();
    chk2("t3_setup", ALGORITHM, 2'd2);
    launch_q.push_back(2'd2);
    KEY_START_N = 1'b0;
    tick(7);
    chk1("t3_pre_start", COP_START, 1'b0);
    tick(1);
    chk1("t3_cop_start", COP_START, 1'b1);
    chk1("t3_busy_launch", BUSY, 1'b1);
    tick(1);
    KEY_START_N = 1'b1;
    KEY_NEXT_N  = 1'b0;
    chk1("t3_cop_start_drop", COP_START, 1'b0);
    for (int i = 0; i < 9; i++) begin
      chk1("t3_busy_wait", BUSY, 1'b1);
      tick(1);
    end
    COP_DONE = 1'b1;
    tick(1);
    COP_DONE = 1'b0;
    chk1("t3_done_led", DONE_LED, 1'b1);
    chk1("t3_busy_off", BUSY, 1'b0);
    chk1("t3_error", ERROR, 1'b0);
    chk2("t3_alg", ALGORITHM, 2'd2);
    KEY_NEXT_N = 1'b1;
    tick(20);
    chk2("t3_alg_frozen", ALGORITHM, 2'd2);
    chk1("t3_done_hold", DONE_LED, 1'b1);

    // 4: timeout after 32 WAIT cycles, late done ignored, start clears fault
    launch_q.push_back(2'd2);
    KEY_START_N = 1'b0;
    tick(8);
    chk1("t4_cop_start", COP_START, 1'b1);
    chk1("t4_done_clr", DONE_LED, 1'b0);
    tick(1);
    KEY_START_N = 1'b1;
    tick(31);
    chk1("t4_err_pre", ERROR, 1'b0);
    chk1("t4_busy_pre", BUSY, 1'b1);
    tick(1);
    chk1("t4_error", ERROR, 1'b1);
    chk1("t4_busy_off", BUSY, 1'b0);
    tick(3);
    COP_DONE = 1'b1;
    tick(1);
    COP_DONE = 1'b0;
    tick(2);
    chk1("t4_err_hold", ERROR, 1'b1);
    chk1("t4_late_done", DONE_LED, 1'b0);
    KEY_START_N = 1'b0;
    tick(7);
    chk1("t4_err_before_ack", ERROR, 1'b1);
    tick(1);
    chk1("t4_err_ack", ERROR, 1'b0);
    chk1("t4_busy_ack", BUSY, 1'b0);
    tick(12);
    KEY_START_N = 1'b1;
    tick(20);
    chk1("t4_idle_busy", BUSY, 1'b0);
    chk1("t4_idle_error", ERROR, 1'b0);

    // 5: done in the same cycle as the last timer count wins
    launch_q.push_back(2'd2);
    KEY_START_N = 1'b0;
    tick(8);
    chk1("t5_cop_start", COP_START, 1'b1);
    tick(1);
    KEY_START_N = 1'b1;
    tick(31);
    chk1("t5_busy", BUSY, 1'b1);
    chk1("t5_err_pre", ERROR, 1'b0);
    COP_DONE = 1'b1;
    tick(1);
    COP_DONE = 1'b0;
    chk1("t5_done_led", DONE_LED, 1'b1);
    chk1("t5_error", ERROR, 1'b0);
    chk1("t5_busy_off", BUSY, 1'b0);

    // 6: reset mid-run, then simultaneous next+start in IDLE
    exp_alg = 2'd3;
    alg_q.push_back(exp_alg);
    press_next();
    chk2("t6_alg3", ALGORITHM, 2'd3);
    chk1("t6_done_clr", DONE_LED, 1'b0);
    launch_q.push_back(2'd3);
    KEY_START_N = 1'b0;
    tick(8);
    chk1("t6_cop_start", COP_START, 1'b1);
    tick(1);
    KEY_START_N = 1'b1;
    tick(5);
    chk1("t6_busy_wait", BUSY, 1'b1);
    alg_q.push_back(2'd0);
    RESET = 1'b1;
    #1;
    chk2("t6_rst_alg", ALGORITHM, 2'd0);
    chk1("t6_rst_busy", BUSY, 1'b0);
    chk1("t6_rst_cop_start", COP_START, 1'b0);
    tick(3);
    RESET = 1'b0;
    tick(20);
    chk2("t6_post_alg", ALGORITHM, 2'd0);
    chk1("t6_post_busy", BUSY, 1'b0);
    chk1("t6_post_done", DONE_LED, 1'b0);
    chk1("t6_post_error", ERROR, 1'b0);
    launch_q.push_back(2'd0);
    KEY_NEXT_N  = 1'b0;
    KEY_START_N = 1'b0;
    tick(8);
    chk1("t6_both_start", COP_START, 1'b1);
    chk2("t6_both_alg", ALGORITHM, 2'd0);
    tick(1);
    KEY_NEXT_N  = 1'b1;
    KEY_START_N = 1'b1;
    tick(3);
    COP_DONE = 1'b1;
    tick(1);
    COP_DONE = 1'b0;
    chk1("t6_both_done", DONE_LED, 1'b1);
    chk2("t6_both_alg_end", ALGORITHM, 2'd0);
    tick(20);

    chki("sb_alg_drained", alg_q.size(), 0);
    chki("sb_launch_drained", launch_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/algorithm_sequencer.md
Name: algorithm_sequencer

Overview:
- Front-panel controller for the scaling coprocessor.
- Debounces the two DE1-SoC pushbuttons, selects the active algorithm (NN, PR, DC, BA) and launches one coprocessor run per start press.
- Tracks completion and timeout of each run.
- ALGORITHM drives both the coprocessor mode input and the seven-segment algorithm display; status outputs drive LEDs.

Parameters:
DEBOUNCE_CYCLES  1000000  consecutive stable cycles required to accept a button level change (20 ms at 50 MHz); minimum 2
TIMEOUT_CYCLES  16777216  cycles allowed in WAIT before declaring a fault; minimum 2

Ports:
CLK  input  1  system clock, all logic on the rising edge
RESET  input  1  asynchronous, active-high reset
KEY_NEXT_N  input  1  raw pushbutton, active-low, asynchronous to CLK; selects the next algorithm
KEY_START_N  input  1  raw pushbutton, active-low, asynchronous to CLK; launches a run
COP_DONE  input  1  coprocessor completion, synchronous to CLK; may be a pulse or a level
ALGORITHM  output  2  selected algorithm: 0=NN, 1=PR, 2=DC, 3=BA
COP_START  output  1  single-cycle launch strobe to the coprocessor
BUSY  output  1  high while a run is outstanding
DONE_LED  output  1  high after a successful run until the next user action
ERROR  output  1  high after a timeout until acknowledged

Behaviour:
- Reset: ALGORITHM=0, COP_START=0, BUSY=0, DONE_LED=0, ERROR=0, state=IDLE, timer=0, debounced levels=1 (released), debounce counters=0.
- Reset asserted mid-run: return to IDLE immediately; no COP_START is issued on release.
- Input path, per key:
  - 2-flop synchronizer.
  - Debounce counter increments while the synced level differs from the debounced level and clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced level flips on the next edge and the counter clears.
  - A 1->0 transition of the debounced level produces a registered press pulse, exactly one cycle wide.
  - Release (0->1) produces no pulse.
  - Latency from the first CLK edge sampling a stable low raw input to the press pulse: DEBOUNCE_CYCLES+3 cycles.
  - Glitches shorter than DEBOUNCE_CYCLES produce no pulse.
  - Holding a key produces exactly one pulse.
- FSM states: IDLE, LAUNCH, WAIT, FINISH, FAULT.
- IDLE:
  - next press: ALGORITHM <= ALGORITHM+1 modulo 4 (3 wraps to 0).
  - start press: go to LAUNCH.
  - Both presses in the same cycle: start wins; ALGORITHM is unchanged.
- LAUNCH:
  - COP_START=1 for this single cycle; timer cleared; BUSY=1.
  - Unconditionally go to WAIT next cycle.
- WAIT:
  - BUSY=1; timer increments each cycle.
  - ALGORITHM is frozen; next and start presses are discarded, not queued.
  - COP_DONE=1: go to FINISH.
  - timer==TIMEOUT_CYCLES-1 with COP_DONE=0: go to FAULT.
  - COP_DONE and timeout in the same cycle: done wins.
  - COP_DONE is not sampled in LAUNCH; a done in the launch cycle is ignored.
- FINISH:
  - BUSY=0; DONE_LED=1.
  - next press: increment ALGORITHM, clear DONE_LED, go to IDLE.
  - start press: clear DONE_LED, go to LAUNCH with the same ALGORITHM.
  - Both presses in the same cycle: start wins.
- FAULT:
  - BUSY=0; ERROR=1.
  - start press: clear ERROR, go to IDLE (no launch).
  - next press ignored.
- COP_DONE is ignored in IDLE, FINISH and FAULT.
- All outputs are registered; state-dependent outputs change on the edge that enters the state.
- Timer width is clog2(TIMEOUT_CYCLES); the timer saturates and never wraps.

Test Plan:
Bench uses DEBOUNCE_CYCLES=4 and TIMEOUT_CYCLES=32.
1. Reset, then four clean KEY_NEXT_N presses (low 20 cycles, high 20 cycles each) -> ALGORITHM steps 1,2,3,0; BUSY, COP_START, DONE_LED and ERROR stay 0.
2. KEY_NEXT_N pulsed low for 3 cycles, then held low for 50 cycles -> glitch ignored; exactly one increment, occurring 7 cycles after the held low begins.
3. ALGORITHM=2, start press; COP_DONE pulsed 10 cycles after COP_START -> exactly one COP_START cycle, BUSY high through WAIT, DONE_LED=1, ALGORITHM stays 2; next press during WAIT has no effect.
4. Start press with no COP_DONE -> ERROR=1 exactly 32 cycles after LAUNCH exits; a later COP_DONE is ignored; a start press clears ERROR and returns to IDLE with no COP_START.
5. COP_DONE asserted in the same cycle the timer reaches 31 -> FINISH (DONE_LED=1, ERROR=0).
6. RESET asserted during WAIT with ALGORITHM=3, then released -> ALGORITHM=0, all status outputs 0, no COP_START; a simultaneous next+start press in IDLE -> one launch, ALGORITHM unchanged.
